multi_debouncer: RTL
====================

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 SHALL provide parameter N, default 5, number of independent button channels (1..32).
REQ-002 SHALL provide parameter CNT_W, default 20, integrator counter width per channel.
REQ-003 SHALL provide parameter TH_ON, default 100000, count at or above which a channel is declared pressed.
REQ-004 SHALL provide parameter TH_OFF, default 50000, count at or below which a channel is declared released.
REQ-005 SHALL provide parameter REPEAT_EN, default 0; 1 enables auto-repeat pulses.
REQ-006 SHALL provide parameter REPEAT_DELAY, default 50000000, hold cycles from press to first repeat pulse.
REQ-007 SHALL provide parameter REPEAT_PERIOD, default 10000000, cycles between subsequent repeat pulses.
REQ-008 SHALL provide port CLK  input  1  system clock; all logic on rising edge.
REQ-009 SHALL provide port RST  input  1  reset, synchronous and active-high.
REQ-010 SHALL provide port BTN  input  N  raw asynchronous button levels, bit i = channel i.
REQ-011 SHALL provide port LEVEL  output  N  debounced, hysteresis-filtered button state.
REQ-012 SHALL provide port PRESS  output  N  one-clock pulse on LEVEL 0->1.
REQ-013 SHALL provide port RELEASE  output  N  one-clock pulse on LEVEL 1->0.
REQ-014 SHALL provide port REPEAT  output  N  one-clock auto-repeat pulse while held.

Function
REQ-015 SHALL synchronise each BTN bit through two flip-flops before any other use.
REQ-016 SHALL, per channel, increment the counter when the synchronised bit is 1 and the counter is below 2^CNT_W-1, and decrement it when the bit is 0 and the counter is above 0; saturate at both bounds, never wrap.
REQ-017 SHALL set LEVEL[i] on the edge after the counter reaches TH_ON while LEVEL[i]=0, and clear it on the edge after the counter reaches TH_OFF while LEVEL[i]=1; otherwise hold (hysteresis band TH_OFF < count < TH_ON).
REQ-018 SHALL assert PRESS[i]/RELEASE[i] for exactly one cycle, registered, coincident with the cycle LEVEL[i] first shows its new value.
REQ-019 SHALL give a latency of TH_ON+2 edges: BTN stable high before edge 0 and count 0 -> LEVEL and PRESS high after edge TH_ON+2; release symmetric from count at saturation.
REQ-020 SHALL, with REPEAT_EN=1, run per channel an FSM IDLE -> HOLD (on PRESS) -> RPT (after REPEAT_DELAY cycles in HOLD, emitting REPEAT) -> RPT (emitting REPEAT every REPEAT_PERIOD cycles).
REQ-021 SHALL return the FSM to IDLE from any state on LEVEL falling; REPEAT SHALL NOT assert in the RELEASE cycle or while in IDLE.
REQ-022 SHALL size the repeat timer to hold max(REPEAT_DELAY, REPEAT_PERIOD) and restart it at 0 on every state entry.
REQ-023 SHALL tie REPEAT to 0 and omit FSM/timer state when REPEAT_EN=0.
REQ-024 SHALL keep channels fully independent; simultaneous events on several channels produce simultaneous pulses.
REQ-025 SHALL require TH_OFF < TH_ON <= 2^CNT_W-1 and REPEAT_DELAY, REPEAT_PERIOD >= 1; violation SHALL be an elaboration error.

Reset
REQ-026 SHALL, while RST=1 at a rising edge, clear synchronisers, counters, LEVEL, PRESS, RELEASE, REPEAT, timers, and set FSMs to IDLE.
REQ-027 SHALL emit no RELEASE when reset clears a high LEVEL mid-operation; a button held through reset needs a full TH_ON integration before PRESS.

Verification (N=2, CNT_W=4, TH_ON=8, TH_OFF=3, REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-028 SHALL verify: BTN[0] 0->1 held -> LEVEL[0] and one-cycle PRESS[0] exactly 10 edges later; counter saturates at 15.
REQ-029 SHALL verify: after saturation, BTN[0] released -> LEVEL[0] clears with RELEASE[0] exactly 14 edges later (15 down to 3, +2 sync).
REQ-030 SHALL verify: bounce BTN[1] alternating every 2 cycles for 200 cycles -> no PRESS/RELEASE, LEVEL[1] stays 0.
REQ-031 SHALL verify: BTN[0] held 60 cycles past PRESS -> REPEAT[0] at PRESS+20, then every 5 cycles; none after RELEASE.
REQ-032 SHALL verify: BTN[0] and BTN[1] rise same cycle -> PRESS=2'b11 in one cycle.
REQ-033 SHALL verify: RST pulsed 1 cycle while LEVEL[0]=1, BTN[0] still high -> all outputs 0, no RELEASE, PRESS[0] again 10 edges after RST low.

Source files
------------

// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer: two-flop synchroniser, saturating integrator with
// hysteresis thresholds, registered press/release pulses and optional auto-repeat.
module multi_debouncer #(
  parameter int N             = 5,
  parameter int CNT_W         = 20,
  parameter int TH_ON         = 100000,
  parameter int TH_OFF        = 50000,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] BTN,
  output logic [N-1:0] LEVEL,
  output logic [N-1:0] PRESS,
  output logic [N-1:0] RELEASE,
  output logic [N-1:0] REPEAT
);

  if (N < 1 || N > 32) begin : g_bad_n
    $error("multi_debouncer: N must be in 1..32");
  end
  if (TH_OFF >= TH_ON) begin : g_bad_th
    $error("multi_debouncer: TH_OFF must be below TH_ON");
  end
  if (longint'(TH_ON) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cnt_w
    $error("multi_debouncer: TH_ON does not fit in CNT_W bits");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
    $error("multi_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ON_C    = CNT_W'(TH_ON);
  localparam logic [CNT_W-1:0] OFF_C   = CNT_W'(TH_OFF);

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             press;
    logic             rel;
    logic             rise;
    logic             fall;

    // Thresholds are checked against the pre-edge count, so the level moves one edge
    // after the count reaches them; reset clears level without a release pulse.
    assign rise = !level && (cnt >= ON_C);
    assign fall = level && (cnt <= OFF_C);

    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt   <= '0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        if (sync2[i] && cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end else if (!sync2[i] && cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
        press <= rise;
        rel   <= fall;
        if (rise) begin
          level <= 1'b1;
        end else if (fall) begin
          level <= 1'b0;
        end
      end
    end

    assign LEVEL[i]   = level;
    assign PRESS[i]   = press;
    assign RELEASE[i] = rel;

    if (REPEAT_EN != 0) begin : g_rpt
      localparam logic [1:0] IDLE = 2'd0;
      localparam logic [1:0] HOLD = 2'd1;
      localparam logic [1:0] RPT  = 2'd2;
      localparam int RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int TMR_W = $clog2(RMAX + 1);
      localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
      localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

      logic [1:0]       state;
      logic [TMR_W-1:0] timer;
      logic             rpt;

      // Timer restarts at 0 on every state entry, including each RPT->RPT pulse.
      always_ff @(posedge CLK) begin
        if (RST) begin
          state <= IDLE;
          timer <= '0;
          rpt   <= 1'b0;
        end else begin
          rpt <= 1'b0;
          if (fall) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            case (state)
              IDLE: begin
                timer <= '0;
                if (rise) state <= HOLD;
              end
              HOLD: begin
                if (timer == DLY_LAST) begin
                  state <= RPT;
                  timer <= '0;
                  rpt   <= 1'b1;
                end else begin
                  timer <= timer + 1'b1;
                end
              end
              RPT: begin
                if (timer == PER_LAST) begin
                  timer <= '0;
                  rpt   <= 1'b1;
                end else begin
                  timer <= timer + 1'b1;
                end
              end
              default: begin
                state <= IDLE;
                timer <= '0;
              end
            endcase
          end
        end
      end

      assign REPEAT[i] = rpt;
    end else begin : g_norpt
      assign REPEAT[i] = 1'b0;
    end
  end

endmodule
